// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/memory stages, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the core-plus-memory view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_done;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          stall_f;
    logic          stall_m;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_done, i_rdata, d_done, d_rdata, stall_f, stall_m,
               m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_done, i_rdata, d_done, d_rdata, stall_f, stall_m,
               m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the I and D ports onto one single-ported memory with LAT wait states.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority.
module mem_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_D, OWN_I} owner_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    if (LAT < 1 || LAT > 15) begin : g_bad_lat
        $error("mem_arbiter: LAT=%0d outside legal range 1..15", LAT);
    end

    state_t        state;
    owner_t        owner;
    owner_t        grant;
    logic          grant_valid;
    logic [3:0]    counter;
    logic          held_we;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_valid = bus.d_req | bus.i_req;
        grant       = OWN_D;
`ifdef MEM_ARB_RR_EN
        if (bus.d_req && bus.i_req) begin
            grant = (owner == OWN_D) ? OWN_I : OWN_D;
        end else if (!bus.d_req) begin
            grant = OWN_I;
        end
`else
        if (!bus.d_req) begin
            grant = OWN_I;
        end
`endif
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= OWN_D;
            counter     <= '0;
            held_we     <= 1'b0;
            bus.m_en    <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.i_done  <= 1'b0;
            bus.d_done  <= 1'b0;
            bus.i_rdata <= '0;
            bus.d_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner    <= grant;
                        counter  <= CNT_INIT;
                        bus.m_en <= 1'b1;
                        state    <= ACCESS;
                        if (grant == OWN_D) begin
                            bus.m_addr  <= bus.d_addr;
                            bus.m_wdata <= bus.d_wdata;
                            held_we     <= bus.d_we;
                            // With LAT=1 the single access cycle is also the commit cycle.
                            bus.m_we    <= bus.d_we && (LAT == 1);
                        end else begin
                            bus.m_addr  <= bus.i_addr;
                            held_we     <= 1'b0;
                            bus.m_we    <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (counter == 4'd0) begin
                        bus.m_en <= 1'b0;
                        bus.m_we <= 1'b0;
                        state    <= RESP;
                        if (owner == OWN_D) begin
                            bus.d_done <= 1'b1;
                            if (!held_we) begin
                                bus.d_rdata <= bus.m_rdata;
                            end
                        end else begin
                            bus.i_done  <= 1'b1;
                            bus.i_rdata <= bus.m_rdata;
                        end
                    end else begin
                        counter  <= counter - 4'd1;
                        // Raise the strobe only for the last cycle so a write commits exactly once.
                        bus.m_we <= held_we && (counter == 4'd1);
                    end
                end
                RESP: begin
                    bus.i_done <= 1'b0;
                    bus.d_done <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.stall_f = bus.i_req & ~bus.i_done;
    assign bus.stall_m = bus.d_req & ~bus.d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (LAT=2, fixed D priority) with a word-array
// memory and a behavioural reference of memory contents and per-port read data.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32), .LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT: combinational read, write on the edge when m_we is high.
    logic [31:0] tb_mem [256] = '{16: 32'h8C02_0004, default: 32'h0};
    assign bus.m_rdata = tb_mem[bus.m_addr[9:2]];
    always @(posedge clk) begin
        if (bus.m_we) tb_mem[bus.m_addr[9:2]] <= bus.m_wdata;
    end

    // Reference: expected memory contents and the value each rdata register should hold.
    logic [31:0] ref_mem [256] = '{16: 32'h8C02_0004, default: 32'h0};
    logic [31:0] exp_i;
    logic [31:0] exp_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fetch: returns the cycles from req to i_done, then leaves the arbiter back in IDLE.
    task automatic do_fetch(input logic [31:0] addr, output int lat);
        bus.i_addr = addr;
        bus.i_req  = 1'b1;
        lat = 0;
        while (!bus.i_done && lat < 50) begin
            step();
            lat++;
        end
        bus.i_req = 1'b0;
        step();
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat);
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_req   = 1'b1;
        lat = 0;
        while (!bus.d_done && lat < 50) begin
            step();
            lat++;
        end
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int d_at;
        int i_at;
        int we_cnt;
        logic [31:0] addr;
        logic [31:0] wdata;

        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        exp_i = '0;
        exp_d = '0;

        // Reset held with a pending fetch: nothing may start.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h40;
        repeat (3) step();
        check("rst_m_en", 32'(bus.m_en), 32'd0);
        check("rst_m_we", 32'(bus.m_we), 32'd0);
        check("rst_i_done", 32'(bus.i_done), 32'd0);
        check("rst_d_done", 32'(bus.d_done), 32'd0);
        check("rst_m_addr", bus.m_addr, 32'h0);
        check("rst_m_wdata", bus.m_wdata, 32'h0);
        check("rst_i_rdata", bus.i_rdata, 32'h0);
        check("rst_d_rdata", bus.d_rdata, 32'h0);
        check("rst_stall_f", 32'(bus.stall_f), 32'd1);

        // Release: I granted, two access cycles, done on the third.
        reset = 1'b1;
        for (int c = 1; c <= LAT + 1; c++) begin
            step();
            check($sformatf("fetch_m_en_c%0d", c), 32'(bus.m_en), (c <= LAT) ? 32'd1 : 32'd0);
            check($sformatf("fetch_done_c%0d", c), 32'(bus.i_done), (c == LAT + 1) ? 32'd1 : 32'd0);
            check($sformatf("fetch_stall_c%0d", c), 32'(bus.stall_f), (c == LAT + 1) ? 32'd0 : 32'd1);
        end
        exp_i = 32'h8C02_0004;
        check("fetch_rdata", bus.i_rdata, exp_i);
        bus.i_req = 1'b0;
        step();

        // Both ports at once: D (a write) first, then I in the next idle slot.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h54; bus.d_wdata = 32'd7;
        bus.i_req = 1'b1; bus.i_addr = 32'h40;
        d_at = -1; i_at = -1; we_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (bus.m_we) we_cnt++;
            if (bus.d_done) begin d_at = c; bus.d_req = 1'b0; bus.d_we = 1'b0; end
            if (bus.i_done) begin i_at = c; bus.i_req = 1'b0; end
        end
        ref_mem[21] = 32'd7;
        check("both_d_done_cycle", 32'(d_at), 32'(LAT + 1));
        check("both_i_done_cycle", 32'(i_at), 32'(2 * LAT + 3));
        check("both_m_we_cycles", 32'(we_cnt), 32'd1);
        check("both_mem_0x54", tb_mem[21], 32'd7);
        check("both_i_rdata", bus.i_rdata, exp_i);
        check("both_d_rdata_untouched", bus.d_rdata, exp_d);

        // Load after store.
        do_data(1'b1, 32'h10, 32'hDEAD_BEEF, lat);
        ref_mem[4] = 32'hDEAD_BEEF;
        check("st_latency", 32'(lat), 32'(LAT + 1));
        check("st_d_rdata_kept", bus.d_rdata, exp_d);
        do_data(1'b0, 32'h10, 32'h0, lat);
        exp_d = 32'hDEAD_BEEF;
        check("ld_latency", 32'(lat), 32'(LAT + 1));
        check("ld_d_rdata", bus.d_rdata, exp_d);
        check("ld_i_rdata_kept", bus.i_rdata, exp_i);

        // Request dropped after the grant still completes.
        bus.i_addr = 32'h54;
        bus.i_req  = 1'b1;
        step();
        bus.i_req = 1'b0;
        lat = 1;
        while (!bus.i_done && lat < 20) begin
            step();
            lat++;
        end
        exp_i = ref_mem[21];
        check("drop_done_cycle", 32'(lat), 32'(LAT + 1));
        check("drop_i_rdata", bus.i_rdata, exp_i);
        step();

        // Random single transactions against the reference memory.
        for (int n = 0; n < 40; n++) begin
            addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            wdata = $urandom;
            case ($urandom_range(0, 2))
                0: begin
                    do_fetch(addr, lat);
                    exp_i = ref_mem[addr[9:2]];
                    check($sformatf("rnd%0d_fetch_lat", n), 32'(lat), 32'(LAT + 1));
                    check($sformatf("rnd%0d_i_rdata", n), bus.i_rdata, exp_i);
                    check($sformatf("rnd%0d_d_rdata", n), bus.d_rdata, exp_d);
                end
                1: begin
                    do_data(1'b0, addr, wdata, lat);
                    exp_d = ref_mem[addr[9:2]];
                    check($sformatf("rnd%0d_load_lat", n), 32'(lat), 32'(LAT + 1));
                    check($sformatf("rnd%0d_d_rdata", n), bus.d_rdata, exp_d);
                    check($sformatf("rnd%0d_i_rdata", n), bus.i_rdata, exp_i);
                end
                default: begin
                    do_data(1'b1, addr, wdata, lat);
                    ref_mem[addr[9:2]] = wdata;
                    check($sformatf("rnd%0d_store_lat", n), 32'(lat), 32'(LAT + 1));
                    check($sformatf("rnd%0d_mem", n), tb_mem[addr[9:2]], wdata);
                    check($sformatf("rnd%0d_d_rdata", n), bus.d_rdata, exp_d);
                end
            endcase
        end

        // Reset during the commit cycle of a write to 0x20 aborts it.
        bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h1234_5678;
        bus.d_req = 1'b1;
        repeat (LAT) step();
        check("abort_m_we_before", 32'(bus.m_we), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_m_we_async", 32'(bus.m_we), 32'd0);
        check("abort_m_en_async", 32'(bus.m_en), 32'd0);
        step();
        check("abort_mem_0x20", tb_mem[8], ref_mem[8]);
        check("abort_no_d_done", 32'(bus.d_done), 32'd0);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        reset = 1'b1;
        we_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus.d_done || bus.m_en) we_cnt++;
        end
        check("abort_quiet_after", 32'(we_cnt), 32'd0);
        check("abort_mem_0x20_final", tb_mem[8], ref_mem[8]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
